reg_writeback_arbiter: RTL and testbench
========================================

Name: reg_writeback_arbiter

Overview:
Shares the single write port of the 8 x 16-bit register file between two writeback sources: ALU results and memory-load results. Each source has a small queue with a valid/ready handshake. A round-robin arbiter drains the queues into registered regWrite/dest/writeData outputs. A per-register pending-write scoreboard gives the issue stage a busy vector for RAW/WAW hazard checks.

Parameters:
DATA_W, 16, register data width
ADDR_W, 3, register address width
NUM_REGS, 8, number of architectural registers
FIFO_DEPTH, 2, entries per source queue (power of two, >= 2)
CNT_W, 2, width of each scoreboard pending counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU queue can accept
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load queue can accept
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
alloc_valid  in  1  issue stage reserves a future write
alloc_addr  in  ADDR_W  register being reserved
alloc_ready  out  1  reservation accepted
busy  out  NUM_REGS  bit i = register i has outstanding writes
wr_en  out  1  to register file regWrite
wr_addr  out  ADDR_W  to register file destination select
wr_data  out  DATA_W  to register file writeData
wr_src  out  1  source of the current write: 0 = ALU, 1 = MEM
err_unalloc  out  1  sticky: a write committed to a register with pending count 0

Behaviour:
- Reset (reset high at an edge): queues empty, RR pointer = ALU last-granted (MEM wins the first tie), all counters 0, wr_en/wr_addr/wr_data/wr_src = 0, err_unalloc = 0. While reset is high, alu_ready, mem_ready and alloc_ready are forced to 0.
- Queues: push on X_valid && X_ready. X_ready = !full, taken from registered state only. A full queue does not accept a push even in a cycle where it pops. A push is never bypassed into arbitration in the same cycle.
- Arbitration, each cycle, over non-empty queue heads:
  - one non-empty: grant it
  - both non-empty: grant the source not granted last; the RR pointer updates only on a grant
  - granted head pops at the edge
- Output register: at the edge, wr_en <= grant, wr_addr/wr_data/wr_src <= granted head. With no grant, wr_en <= 0 and addr/data/src hold their values.
- Latency: a request accepted at edge E0 drives wr_en high in the cycle after edge E1 at the earliest (one cycle queue-to-output). The register file commits it at edge E2.
- Ordering: FIFO order is preserved within each source. No ordering is guaranteed across sources; the issue stage must use busy to avoid WAW hazards across sources.
- Scoreboard: one CNT_W counter per register.
  - inc = alloc_valid && alloc_ready on alloc_addr
  - dec = wr_en high on wr_addr, applied at the edge ending that cycle
  - inc and dec on the same register in the same cycle: counter unchanged
  - alloc_ready = (count[alloc_addr] != 2^CNT_W-1), from registered state only
  - busy[i] = (count[i] != 0)
- Unallocated write: if wr_en is high and count[wr_addr] == 0, the write still proceeds, the counter stays 0 (no wrap), and err_unalloc sets. It clears only on reset.
- Reset mid-operation: all queued entries are dropped and counters cleared. No wr_en is asserted in the cycle following reset.

Decomposition:
- Shared package: DATA_W, ADDR_W, NUM_REGS constants; source encoding SRC_ALU = 0, SRC_MEM = 1.
- Sub-module wb_fifo (parameterized synchronous FIFO with valid/ready push, pop and empty/full flags), instantiated once per source.
- Arbiter and scoreboard stay in the top module.

Test Plan:
- Reset, then ALU push (addr 3, 0x1234) at edge E0 -> wr_en = 1, wr_addr = 3, wr_data = 0x1234, wr_src = 0 in the cycle after E1, for exactly one cycle; err_unalloc = 1 (no alloc was made).
- After reset, push ALU (1, 0xAAAA) and MEM (2, 0x5555) in the same cycle -> MEM write appears first, ALU write in the next cycle.
- Hold alu_valid and mem_valid high for 6 cycles with distinct data -> wr_src alternates 1, 0, 1, 0, ...; each ready drops to 0 while its queue holds 2 entries; no entry is lost or duplicated.
- Alloc reg 5 three times -> busy[5] = 1; a fourth alloc to 5 sees alloc_ready = 0. Three ALU writes to 5 -> busy[5] clears after the third commits; err_unalloc stays 0.
- With count[4] = 1, alloc reg 4 in the same cycle its write has wr_en high -> count stays 1 and busy[4] stays 1; a subsequent write to 4 clears it.
- Fill both queues and hold alloc counts nonzero, then assert reset for 1 cycle -> wr_en = 0 in the next cycle, busy = 0, both readies = 1 after reset deasserts.

Source files
------------

// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   DATA_W / ADDR_W / NUM_REGS : register file geometry
//   SRC_ALU / SRC_MEM          : encoding of wr_src
//   wb_entry_t                 : one queued writeback (destination + data)
package reg_writeback_arbiter_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO used as a per-source writeback queue.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   i_push     : write i_data (ignored when full, even if popping this cycle)
//   i_pop      : drop the head entry (ignored when empty)
//   o_head     : current head entry
//   o_empty    : no entries held
//   o_full     : DEPTH entries held
module wb_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [PW:0]      r_cnt;
    logic             w_push, w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_head  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/reg_writeback_arbiter.sv
// Shares the register-file write port between ALU and load writebacks.
// Each source feeds a queue; a round-robin arbiter drains the queue heads
// into registered wr_* outputs. A per-register pending-write counter set
// drives the busy vector used by issue for RAW/WAW hazard checks.
//   alu_* / mem_*  : valid/ready writeback requests
//   alloc_*        : issue-stage reservation of a future write
//   busy           : registers with outstanding writes
//   wr_*           : register file write port (wr_src 0 = ALU, 1 = MEM)
//   err_unalloc    : sticky, a write committed to a register with count 0
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                alloc_valid,
    input  logic [ADDR_W-1:0]   alloc_addr,
    output logic                alloc_ready,
    output logic [NUM_REGS-1:0] busy,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_src,
    output logic                err_unalloc
);
    wb_entry_t w_alu_head, w_mem_head, w_ghead;
    logic      w_alu_empty, w_alu_full, w_mem_empty, w_mem_full;
    logic      w_grant, w_gsrc, w_alu_pop, w_mem_pop, w_alloc_fire;
    logic [NUM_REGS-1:0] w_inc, w_dec;

    logic                r_last;   // source granted most recently
    logic                r_wr_en, r_wr_src, r_err;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [CNT_W-1:0]    r_cnt [NUM_REGS];

    // Readies come from registered state only; reset masks them.
    assign alu_ready   = !reset && !w_alu_full;
    assign mem_ready   = !reset && !w_mem_full;
    assign alloc_ready = !reset && (r_cnt[alloc_addr] != '1);
    assign w_alloc_fire = alloc_valid && alloc_ready;

    wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_alu_q (
        .clk     (clk),
        .reset   (reset),
        .i_push  (alu_valid && alu_ready),
        .i_data  ({alu_addr, alu_data}),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_empty (w_alu_empty),
        .o_full  (w_alu_full)
    );

    wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_mem_q (
        .clk     (clk),
        .reset   (reset),
        .i_push  (mem_valid && mem_ready),
        .i_data  ({mem_addr, mem_data}),
        .i_pop   (w_mem_pop),
        .o_head  (w_mem_head),
        .o_empty (w_mem_empty),
        .o_full  (w_mem_full)
    );

    // Round robin: on a tie, the source not granted last wins; otherwise
    // whichever queue is non-empty. Only registered heads compete.
    always_comb begin
        w_grant = !w_alu_empty || !w_mem_empty;
        if (!w_alu_empty && !w_mem_empty) w_gsrc = ~r_last;
        else                              w_gsrc = !w_mem_empty;
        w_alu_pop = w_grant && (w_gsrc == SRC_ALU);
        w_mem_pop = w_grant && (w_gsrc == SRC_MEM);
        w_ghead   = (w_gsrc == SRC_MEM) ? w_mem_head : w_alu_head;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last    <= SRC_ALU;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_src  <= 1'b0;
        end else begin
            r_wr_en <= w_grant;
            if (w_grant) begin
                r_last    <= w_gsrc;
                r_wr_addr <= w_ghead.addr;
                r_wr_data <= w_ghead.data;
                r_wr_src  <= w_gsrc;
            end
        end
    end

    // Scoreboard: increment on accepted alloc, decrement when the write on
    // the output register commits; both at once cancel out.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        busy  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc[i] = w_alloc_fire && (alloc_addr == ADDR_W'(i));
            w_dec[i] = r_wr_en && (r_wr_addr == ADDR_W'(i));
            busy[i]  = (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
            // The write itself still goes ahead; only the flag records it.
            if (r_wr_en && r_cnt[r_wr_addr] == '0) r_err <= 1'b1;
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign wr_src      = r_wr_src;
    assign err_unalloc = r_err;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst, av, mv, lv;
    logic [2:0]  aa, ma, la;
    logic [15:0] ad, md;
    logic        alu_ready, mem_ready, alloc_ready;
    logic [7:0]  busy;
    logic        wr_en, wr_src, err_unalloc;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    reg_writeback_arbiter dut (
        .clk(clk), .reset(rst),
        .alu_valid(av), .alu_ready(alu_ready), .alu_addr(aa), .alu_data(ad),
        .mem_valid(mv), .mem_ready(mem_ready), .mem_addr(ma), .mem_data(md),
        .alloc_valid(lv), .alloc_addr(la), .alloc_ready(alloc_ready),
        .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_src(wr_src), .err_unalloc(err_unalloc)
    );

    // {wr_en, wr_addr, wr_data, wr_src, busy, err, alu_rdy, mem_rdy, alloc_rdy}
    typedef struct {
        logic rst, av; logic [2:0] aa; logic [15:0] ad;
        logic mv; logic [2:0] ma; logic [15:0] md;
        logic lv; logic [2:0] la;
        logic [32:0] exp;
    } vec_t;

    function automatic vec_t V(bit r, bit a_v, int a_a, int a_d, bit m_v, int m_a, int m_d,
                               bit l_v, int l_a, bit we, int wa, int wd, bit ws, int bsy,
                               bit er, bit ar, bit mr, bit lr);
        vec_t t;
        t.rst = r; t.av = a_v; t.aa = 3'(a_a); t.ad = 16'(a_d);
        t.mv = m_v; t.ma = 3'(m_a); t.md = 16'(m_d); t.lv = l_v; t.la = 3'(l_a);
        t.exp = {we, 3'(wa), 16'(wd), ws, 8'(bsy), er, ar, mr, lr};
        return t;
    endfunction

    function automatic logic [32:0] obs();
        return {wr_en, wr_addr, wr_data, wr_src, busy, err_unalloc, alu_ready, mem_ready, alloc_ready};
    endfunction

    // Reference model: queues of {addr,data}, counts per register.
    logic [18:0] qa[$], qm[$];
    int          mc[8];
    bit          mlast, mer, mwe, mws;
    logic [2:0]  mwa;
    logic [15:0] mwd;

    task automatic model_step();
        bit acc_a, acc_m, acc_l;
        logic [18:0] e;
        if (rst) begin
            qa.delete(); qm.delete();
            foreach (mc[i]) mc[i] = 0;
            mlast = 0; mer = 0; mwe = 0; mwa = 0; mwd = 0; mws = 0;
        end else begin
            acc_a = av && qa.size() < 2;
            acc_m = mv && qm.size() < 2;
            acc_l = lv && mc[la] != 3;
            if (mwe && mc[mwa] == 0) mer = 1;
            foreach (mc[i]) begin
                mc[i] = mc[i] + int'(acc_l && la == 3'(i)) - int'(mwe && mwa == 3'(i));
                if (mc[i] < 0) mc[i] = 0;
            end
            mwe = 0;
            if (qa.size() > 0 || qm.size() > 0) begin
                if (qa.size() > 0 && qm.size() > 0) mws = !mlast;
                else                                 mws = (qm.size() > 0);
                e = mws ? qm.pop_front() : qa.pop_front();
                mwe = 1; mwa = e[18:16]; mwd = e[15:0]; mlast = mws;
            end
            if (acc_a) qa.push_back({aa, ad});
            if (acc_m) qm.push_back({ma, md});
        end
    endtask

    function automatic logic [32:0] model_exp();
        logic [7:0] b;
        foreach (mc[i]) b[i] = (mc[i] != 0);
        return {mwe, mwa, mwd, mws, b, mer, !rst && qa.size() < 2, !rst && qm.size() < 2,
                !rst && mc[la] != 3};
    endfunction

    task automatic check(string name, logic [32:0] act, logic [32:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(bit r, bit a_v, int a_a, int a_d, bit m_v, int m_a, int m_d, bit l_v, int l_a);
        rst = r; av = a_v; aa = 3'(a_a); ad = 16'(a_d);
        mv = m_v; ma = 3'(m_a); md = 16'(m_d); lv = l_v; la = 3'(l_a);
    endtask

    vec_t tbl[28];
    bit   exp_src;
    int   nwr;

    initial begin
        set_in(1, 0,0,0, 0,0,0, 0,0);
        //            rst av aa ad      mv ma md      lv la | we wa wd      ws bsy  er ar mr lr
        tbl[0]  = V(1, 0,0,0,        0,0,0,        0,0,   0,0,0,        0,'h00,0, 0,0,0);
        tbl[1]  = V(0, 1,3,'h1234,   0,0,0,        0,0,   0,0,0,        0,'h00,0, 1,1,1);
        tbl[2]  = V(0, 0,0,0,        0,0,0,        0,0,   1,3,'h1234,   0,'h00,0, 1,1,1);
        tbl[3]  = V(0, 0,0,0,        0,0,0,        0,0,   0,3,'h1234,   0,'h00,1, 1,1,1);
        tbl[4]  = V(1, 0,0,0,        0,0,0,        0,0,   0,0,0,        0,'h00,0, 0,0,0);
        tbl[5]  = V(0, 1,1,'hAAAA,   1,2,'h5555,   0,0,   0,0,0,        0,'h00,0, 1,1,1);
        tbl[6]  = V(0, 0,0,0,        0,0,0,        0,0,   1,2,'h5555,   1,'h00,0, 1,1,1);
        tbl[7]  = V(0, 0,0,0,        0,0,0,        0,0,   1,1,'hAAAA,   0,'h00,1, 1,1,1);
        tbl[8]  = V(0, 0,0,0,        0,0,0,        0,0,   0,1,'hAAAA,   0,'h00,1, 1,1,1);
        tbl[9]  = V(1, 0,0,0,        0,0,0,        0,0,   0,0,0,        0,'h00,0, 0,0,0);
        tbl[10] = V(0, 0,0,0,        0,0,0,        1,5,   0,0,0,        0,'h20,0, 1,1,1);
        tbl[11] = V(0, 0,0,0,        0,0,0,        1,5,   0,0,0,        0,'h20,0, 1,1,1);
        tbl[12] = V(0, 0,0,0,        0,0,0,        1,5,   0,0,0,        0,'h20,0, 1,1,0);
        tbl[13] = V(0, 1,5,'h0001,   0,0,0,        1,5,   0,0,0,        0,'h20,0, 1,1,0);
        tbl[14] = V(0, 1,5,'h0002,   0,0,0,        0,0,   1,5,'h0001,   0,'h20,0, 1,1,1);
        tbl[15] = V(0, 1,5,'h0003,   0,0,0,        0,0,   1,5,'h0002,   0,'h20,0, 1,1,1);
        tbl[16] = V(0, 0,0,0,        0,0,0,        0,0,   1,5,'h0003,   0,'h20,0, 1,1,1);
        tbl[17] = V(0, 0,0,0,        0,0,0,        0,0,   0,5,'h0003,   0,'h00,0, 1,1,1);
        tbl[18] = V(0, 1,4,'h0044,   0,0,0,        1,4,   0,5,'h0003,   0,'h10,0, 1,1,1);
        tbl[19] = V(0, 0,0,0,        0,0,0,        0,0,   1,4,'h0044,   0,'h10,0, 1,1,1);
        tbl[20] = V(0, 0,0,0,        0,0,0,        1,4,   0,4,'h0044,   0,'h10,0, 1,1,1);
        tbl[21] = V(0, 1,4,'h0045,   0,0,0,        0,0,   0,4,'h0044,   0,'h10,0, 1,1,1);
        tbl[22] = V(0, 0,0,0,        0,0,0,        0,0,   1,4,'h0045,   0,'h10,0, 1,1,1);
        tbl[23] = V(0, 0,0,0,        0,0,0,        0,0,   0,4,'h0045,   0,'h00,0, 1,1,1);
        tbl[24] = V(0, 1,6,'h0066,   1,7,'h0077,   1,6,   0,4,'h0045,   0,'h40,0, 1,1,1);
        tbl[25] = V(0, 1,6,'h0067,   1,7,'h0078,   1,7,   1,7,'h0077,   1,'hC0,0, 0,1,1);
        tbl[26] = V(1, 1,6,'h0067,   1,7,'h0078,   1,7,   0,0,0,        0,'h00,0, 0,0,0);
        tbl[27] = V(0, 0,0,0,        0,0,0,        0,0,   0,0,0,        0,'h00,0, 1,1,1);

        for (int i = 0; i < 28; i++) begin
            set_in(tbl[i].rst, tbl[i].av, int'(tbl[i].aa), int'(tbl[i].ad), tbl[i].mv,
                   int'(tbl[i].ma), int'(tbl[i].md), tbl[i].lv, int'(tbl[i].la));
            step();
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // Burst: both sources held valid for 6 cycles, then drained.
        set_in(1, 0,0,0, 0,0,0, 0,0);
        step();
        check("burst_reset", obs(), model_exp());
        exp_src = 1'b1;
        nwr = 0;
        for (int k = 0; k < 11; k++) begin
            if (k < 6) set_in(0, 1, k, 'hA000 + k, 1, k + 1, 'hB000 + k, 0, 0);
            else       set_in(0, 0,0,0, 0,0,0, 0,0);
            step();
            check($sformatf("burst%0d", k), obs(), model_exp());
            if (wr_en) begin
                nwr++;
                check($sformatf("burst_alt%0d", k), {32'd0, wr_src}, {32'd0, exp_src});
                exp_src = !exp_src;
            end
        end
        check("burst_writes", 33'(nwr), 33'd8);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            set_in($urandom_range(0, 49) == 0,
                   $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 65535),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 65535),
                   $urandom_range(0, 9) < 4, $urandom_range(0, 7));
            step();
            check($sformatf("rand%0d", k), obs(), model_exp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
